// File: rtl/uart_rx_frame_parser.sv
// Frames SOF/LEN/payload/XOR-checksum packets from a UART byte stream, then releases the payload on valid/ready.
// Optional inter-byte timeout is enabled by defining UART_FRAME_TIMEOUT_EN.
module uart_rx_frame_parser #(
    parameter int                D_BITS         = 8,
    parameter int                MAX_LEN        = 16,
    parameter logic [D_BITS-1:0] SOF            = 8'hA5,
    parameter int                TIMEOUT_CYCLES = 10_000
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [D_BITS-1:0]            i_rx_data,
    input  logic                         i_rx_done,
    output logic [D_BITS-1:0]            o_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic                         o_last,
    output logic [$clog2(MAX_LEN+1)-1:0] o_len,
    output logic                         o_frame_ok,
    output logic                         o_crc_err,
    output logic                         o_len_err,
    output logic                         o_overrun,
    output logic                         o_timeout,
    output logic                         o_busy
);
    localparam int LW    = $clog2(MAX_LEN + 1);
    localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CSUM, S_DRAIN} state_t;

    state_t            state;
    logic [LW-1:0]     len;
    logic [LW-1:0]     wr_cnt;
    logic [LW-1:0]     rd_ptr;
    logic [LW-1:0]     rd_nxt;
    logic [D_BITS-1:0] csum;
    logic [D_BITS-1:0] mem [DEPTH];
    logic              tmo_hit;

    assign rd_nxt = rd_ptr + LW'(1);
    assign o_busy = (state != S_IDLE);

    // Payload storage carries no reset; contents are only read after a full frame is written.
    always_ff @(posedge i_clk) begin
        if (state == S_PAYLOAD && i_rx_done) begin
            mem[wr_cnt[AW-1:0]] <= i_rx_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= S_IDLE;
            len        <= '0;
            wr_cnt     <= '0;
            rd_ptr     <= '0;
            csum       <= '0;
            o_data     <= '0;
            o_valid    <= 1'b0;
            o_last     <= 1'b0;
            o_len      <= '0;
            o_frame_ok <= 1'b0;
            o_crc_err  <= 1'b0;
            o_len_err  <= 1'b0;
            o_overrun  <= 1'b0;
        end else begin
            o_frame_ok <= 1'b0;
            o_crc_err  <= 1'b0;
            o_len_err  <= 1'b0;
            o_overrun  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_rx_done && i_rx_data == SOF) state <= S_LEN;
                end
                S_LEN: begin
                    if (i_rx_done) begin
                        if (i_rx_data == '0 || int'(i_rx_data) > MAX_LEN) begin
                            o_len_err <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            len    <= LW'(i_rx_data);
                            csum   <= i_rx_data;
                            wr_cnt <= '0;
                            state  <= S_PAYLOAD;
                        end
                    end else if (tmo_hit) begin
                        state <= S_IDLE;
                    end
                end
                S_PAYLOAD: begin
                    if (i_rx_done) begin
                        csum   <= csum ^ i_rx_data;
                        wr_cnt <= wr_cnt + LW'(1);
                        if (wr_cnt == len - LW'(1)) state <= S_CSUM;
                    end else if (tmo_hit) begin
                        state <= S_IDLE;
                    end
                end
                S_CSUM: begin
                    if (i_rx_done) begin
                        if (i_rx_data == csum) begin
                            o_frame_ok <= 1'b1;
                            o_len      <= len;
                            rd_ptr     <= '0;
                            o_data     <= mem[0];
                            o_last     <= (len == LW'(1));
                            o_valid    <= 1'b1;
                            state      <= S_DRAIN;
                        end else begin
                            o_crc_err <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end else if (tmo_hit) begin
                        state <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (i_rx_done) o_overrun <= 1'b1;
                    // Prefetch the next byte on each transfer so a ready consumer sees one byte per cycle.
                    if (o_valid && i_ready) begin
                        if (o_last) begin
                            o_valid <= 1'b0;
                            o_last  <= 1'b0;
                            state   <= S_IDLE;
                        end else begin
                            rd_ptr <= rd_nxt;
                            o_data <= mem[rd_nxt[AW-1:0]];
                            o_last <= (rd_nxt == len - LW'(1));
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] tmo_cnt;
    logic          tmo_active;

    assign tmo_active = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CSUM);
    // Firing one count early lets the registered pulse land exactly TIMEOUT_CYCLES after the last strobe.
    assign tmo_hit    = tmo_active && !i_rx_done && (tmo_cnt == TW'(TIMEOUT_CYCLES - 2));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tmo_cnt   <= '0;
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= tmo_hit;
            if (tmo_active && !i_rx_done && !tmo_hit) tmo_cnt <= tmo_cnt + TW'(1);
            else                                      tmo_cnt <= '0;
        end
    end
`else
    assign tmo_hit   = 1'b0;
    assign o_timeout = 1'b0;
`endif

endmodule
